// File: rtl/vram_arbiter.sv
// vram_arbiter
// Two-client arbiter and byte-lane adapter in front of the 16Kx16 single-port
// VRAM macro. A 16-bit video read port and an 8-bit CPU byte port share the
// macro. The CPU side has a one-entry request buffer, so the CPU strobe is
// only one cycle wide. A small return pipeline routes each one-cycle-late read
// word back to the client that issued it.
//
// Configuration macro: VRAM_ARB_STARVE_GUARD_EN
//   defined   -> a pending CPU access overrides video after STARVE_LIMIT
//                consecutive denied cycles
//   undefined -> video has strict priority and STARVE_LIMIT has no effect
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   vid_req/vid_addr    video read request (level) and word address
//   vid_ack             video grant this cycle (combinational)
//   vid_rdata/vid_rvalid  video read return, one cycle after vid_ack
//   cpu_req/cpu_addr/cpu_we/cpu_wdata  one-cycle CPU byte access strobe
//   cpu_busy            buffer cannot take cpu_req this cycle (combinational)
//   cpu_rdata/cpu_rvalid  CPU read byte return
//   ram_ad/ram_di/ram_maskwe/ram_we/ram_cs  macro drive, ram_do macro read data
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  output logic        vid_rvalid,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [13:0] ram_ad,
  output logic [15:0] ram_di,
  output logic [3:0]  ram_maskwe,
  output logic        ram_we,
  output logic        ram_cs,
  input  logic [15:0] ram_do
);

  // Nibble write mask for a byte lane: lane 1 is the high byte.
  function automatic logic [3:0] lane_mask(input logic lane);
    logic [3:0] mask;
    if (lane) begin
      mask = 4'b1100;
    end else begin
      mask = 4'b0011;
    end
    return mask;
  endfunction

  // Byte of a macro word selected by the byte lane.
  function automatic logic [7:0] lane_byte(input logic lane, input logic [15:0] word);
    logic [7:0] b;
    if (lane) begin
      b = word[15:8];
    end else begin
      b = word[7:0];
    end
    return b;
  endfunction

  logic        buf_valid_r;
  logic [14:0] buf_addr_r;
  logic        buf_we_r;
  logic [7:0]  buf_data_r;
  logic        vid_rd_r;
  logic        cpu_rd_r;
  logic        lane_r;
  logic        cpu_grant_s;
  logic        vid_grant_s;
  logic        cpu_busy_s;
  logic        buf_load_s;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_r;
`else
  // The limit only matters with the guard; this empty block keeps it referenced.
  if (STARVE_LIMIT == 0) begin : g_limit_unused
  end
`endif

  // Grant decision. Reset suppresses all macro traffic, even with requests held.
  always_comb begin
    cpu_grant_s = 1'b0;
    vid_grant_s = 1'b0;
    if (rst) begin
      cpu_grant_s = 1'b0;
      vid_grant_s = 1'b0;
    end else begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
      cpu_grant_s = buf_valid_r & (~vid_req | (starve_cnt_r >= STARVE_LIMIT_C));
`else
      cpu_grant_s = buf_valid_r & ~vid_req;
`endif
      vid_grant_s = vid_req & ~cpu_grant_s;
    end
  end

  // The buffer frees up in the cycle its entry is granted, so a new strobe
  // can load back to back with no bubble.
  assign cpu_busy_s = buf_valid_r & ~cpu_grant_s;
  assign buf_load_s = cpu_req & ~cpu_busy_s;
  assign cpu_busy   = cpu_busy_s;
  assign vid_ack    = vid_grant_s;

  // Macro pin drive for the granted client; idle pins are all zero.
  always_comb begin
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_ad     = 14'h0000;
    ram_di     = 16'h0000;
    ram_maskwe = 4'b0000;
    if (cpu_grant_s) begin
      ram_cs     = 1'b1;
      ram_we     = buf_we_r;
      ram_ad     = buf_addr_r[14:1];
      ram_di     = {buf_data_r, buf_data_r};
      ram_maskwe = lane_mask(buf_addr_r[0]);
    end else if (vid_grant_s) begin
      ram_cs     = 1'b1;
      ram_ad     = vid_addr;
    end else begin
      ram_cs     = 1'b0;
    end
  end

  // One-entry CPU request buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= 15'h0000;
      buf_we_r    <= 1'b0;
      buf_data_r  <= 8'h00;
    end else if (buf_load_s) begin
      buf_valid_r <= 1'b1;
      buf_addr_r  <= cpu_addr;
      buf_we_r    <= cpu_we;
      buf_data_r  <= cpu_wdata;
    end else if (cpu_grant_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

`ifdef VRAM_ARB_STARVE_GUARD_EN
  // Counts consecutive cycles a buffered CPU access lost to video, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= 4'h0;
    end else if (buf_valid_r & ~cpu_grant_s) begin
      if (starve_cnt_r >= STARVE_LIMIT_C) begin
        starve_cnt_r <= STARVE_LIMIT_C;
      end else begin
        starve_cnt_r <= starve_cnt_r + 4'h1;
      end
    end else begin
      starve_cnt_r <= 4'h0;
    end
  end
`endif

  // Return pipeline: remembers who owns next cycle's ram_do. Writes return nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_rd_r <= 1'b0;
      cpu_rd_r <= 1'b0;
      lane_r   <= 1'b0;
    end else begin
      vid_rd_r <= vid_grant_s;
      cpu_rd_r <= cpu_grant_s & ~buf_we_r;
      lane_r   <= buf_addr_r[0];
    end
  end

  // Read returns, masked while reset is held so an in-flight read never surfaces.
  always_comb begin
    vid_rvalid = vid_rd_r & ~rst;
    cpu_rvalid = cpu_rd_r & ~rst;
    if (vid_rvalid) begin
      vid_rdata = ram_do;
    end else begin
      vid_rdata = 16'h0000;
    end
    if (cpu_rvalid) begin
      cpu_rdata = lane_byte(lane_r, ram_do);
    end else begin
      cpu_rdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed steps, a behavioural VRAM
// macro, and scoreboards of expected read returns with their return cycle.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [13:0] ram_ad;
  logic [15:0] ram_di;
  logic [3:0]  ram_maskwe;
  logic        ram_we;
  logic        ram_cs;
  logic [15:0] ram_do;
  logic        ram_init;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          when;
  } exp_t;

  exp_t vq[$];
  exp_t cq[$];
  logic [15:0] mem [0:16383];
  logic [15:0] ref_mem [0:3];

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_maskwe(ram_maskwe),
    .ram_we(ram_we), .ram_cs(ram_cs), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int k);
    logic [15:0] w;
    case (k)
      0: w = 16'h0F0F;
      1: w = 16'h1234;
      2: w = 16'hBEEF;
      3: w = 16'hC0DE;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Behavioural macro: registered read, nibble-masked write at the clock edge.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 4; k++) mem[k] <= init_word(k);
    end else if (ram_cs === 1'b1) begin
      if (ram_we === 1'b1) begin
        for (int n = 0; n < 4; n++)
          if (ram_maskwe[n]) mem[ram_ad][n*4 +: 4] <= ram_di[n*4 +: 4];
      end else begin
        ram_do <= mem[ram_ad];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Return monitor: every rvalid must match the oldest expected entry and its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (vid_rvalid === 1'b1) begin
      if (vq.size() == 0) begin
        check("vid_unexpected_rvalid", 32'(vid_rvalid), 32'd0);
      end else begin
        e = vq.pop_front();
        check("vid_rdata", 32'(vid_rdata), 32'(e.data));
        check("vid_rcycle", 32'(cyc), 32'(e.when));
      end
    end
    if (cpu_rvalid === 1'b1) begin
      if (cq.size() == 0) begin
        check("cpu_unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
      end else begin
        e = cq.pop_front();
        check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
        check("cpu_rcycle", 32'(cyc), 32'(e.when));
      end
    end
  end

  // Protocol: the CPU must never strobe while the buffer is busy.
  always @(negedge clk) begin
    if (rst === 1'b0 && cpu_req === 1'b1 && cpu_busy === 1'b1) begin
      failures++;
      $error("FAIL cpu_req_while_busy observed=1 expected=0");
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Drive a CPU strobe; writes update the reference, reads queue a return lat cycles later.
  task automatic cpu_issue(input logic [14:0] a, input logic w, input logic [7:0] d, input int lat);
    exp_t e;
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = d;
    if (w) begin
      if (a[0]) ref_mem[a[14:1]][15:8] = d;
      else      ref_mem[a[14:1]][7:0]  = d;
    end else if (lat > 0) begin
      e.data = a[0] ? {8'h00, ref_mem[a[14:1]][15:8]} : {8'h00, ref_mem[a[14:1]][7:0]};
      e.when = cyc + lat;
      cq.push_back(e);
    end
  endtask

  task automatic vid_expect(input logic [13:0] a);
    exp_t e;
    e.data = ref_mem[a];
    e.when = cyc + 1;
    vq.push_back(e);
  endtask

  initial begin
    bit guard;
    bit exp_cpu;
    bit exp_busy;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    for (int k = 0; k < 4; k++) ref_mem[k] = init_word(k);
    rst = 1'b1; ram_init = 1'b1;
    vid_req = 1'b1; vid_addr = 14'h0000;
    cpu_req = 1'b1; cpu_addr = 15'h0000; cpu_we = 1'b0; cpu_wdata = 8'h00;

    // Reset held two cycles with both requests asserted.
    next_cycle();
    ram_init = 1'b0;
    next_cycle();
    settle();
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_ram_pins", {ram_ad, ram_maskwe, ram_we, 13'h0}, 32'd0);
    check("rst_ram_di", 32'(ram_di), 32'd0);
    check("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    check("rst_rvalids", {30'd0, vid_rvalid, cpu_rvalid}, 32'd0);
    check("rst_rdata", {8'h00, cpu_rdata, vid_rdata}, 32'd0);
    next_cycle();
    rst = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
    settle();
    check("post_rst_rvalids", {30'd0, vid_rvalid, cpu_rvalid}, 32'd0);
    check("post_rst_busy", 32'(cpu_busy), 32'd0);
    check("post_rst_ram_cs", 32'(ram_cs), 32'd0);

    // Byte writes to both lanes of word 0, then read-back of each lane.
    next_cycle();
    cpu_issue(15'h0001, 1'b1, 8'hA5, 0);
    settle();
    check("wr1_busy", 32'(cpu_busy), 32'd0);
    check("wr1_not_yet_granted", 32'(ram_cs), 32'd0);
    next_cycle();
    cpu_issue(15'h0000, 1'b1, 8'h3C, 0);
    settle();
    check("wr1_cs_we", {30'd0, ram_cs, ram_we}, 32'd3);
    check("wr1_maskwe", 32'(ram_maskwe), 32'b1100);
    check("wr1_ad", 32'(ram_ad), 32'd0);
    check("wr1_di", 32'(ram_di), 32'hA5A5);
    check("wr2_load_no_bubble_busy", 32'(cpu_busy), 32'd0);
    next_cycle();
    cpu_issue(15'h0001, 1'b0, 8'h00, 2);
    settle();
    check("wr2_cs_we", {30'd0, ram_cs, ram_we}, 32'd3);
    check("wr2_maskwe", 32'(ram_maskwe), 32'b0011);
    check("wr2_di", 32'(ram_di), 32'h3C3C);
    next_cycle();
    cpu_issue(15'h0000, 1'b0, 8'h00, 2);
    settle();
    check("rd1_cs_we", {30'd0, ram_cs, ram_we}, 32'd2);
    check("rd1_ad", 32'(ram_ad), 32'd0);
    check("word0_after_writes", 32'(mem[0]), 32'hA53C);
    next_cycle();
    cpu_req = 1'b0;
    settle();
    check("rd2_cs", 32'(ram_cs), 32'd1);
    next_cycle();
    settle();

    // Video streaming, one word per cycle.
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      vid_req = 1'b1; vid_addr = 14'(k);
      settle();
      check("vid_stream_ack", 32'(vid_ack), 32'd1);
      check("vid_stream_pins", {ram_ad, ram_we, ram_cs}, {14'(k), 2'b01});
      if (vid_ack === 1'b1) vid_expect(14'(k));
    end
    next_cycle();
    vid_req = 1'b0;
    settle();
    check("vid_stream_idle_ack", 32'(vid_ack), 32'd0);

    // Continuous video plus one CPU read of word 3, high byte.
    next_cycle();
    vid_req = 1'b1; vid_addr = 14'h0002;
    cpu_issue(15'h0007, 1'b0, 8'h00, guard ? 6 : 9);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        next_cycle();
        cpu_req = 1'b0;
      end
      settle();
      exp_cpu  = guard && (i == 5);
      exp_busy = guard ? (i >= 1 && i <= 4) : (i >= 1);
      check("starve_vid_ack", 32'(vid_ack), 32'(!exp_cpu));
      check("starve_cpu_busy", 32'(cpu_busy), 32'(exp_busy));
      if (exp_cpu) check("starve_cpu_pins", {ram_ad, ram_we, ram_cs}, {14'h0003, 2'b01});
      if (vid_ack === 1'b1) vid_expect(14'h0002);
    end
    next_cycle();
    vid_req = 1'b0;
    settle();
    check("starve_drop_vid_ack", 32'(vid_ack), 32'd0);
    if (guard) check("starve_drop_cs", 32'(ram_cs), 32'd0);
    else       check("strict_drop_cpu_pins", {ram_ad, ram_we, ram_cs}, {14'h0003, 2'b01});
    next_cycle();
    settle();

    // Reset arriving the cycle after a CPU read grant.
    next_cycle();
    cpu_issue(15'h0002, 1'b0, 8'h00, 0);
    settle();
    next_cycle();
    cpu_req = 1'b0;
    settle();
    check("midrst_grant_pins", {ram_ad, ram_we, ram_cs}, {14'h0001, 2'b01});
    next_cycle();
    rst = 1'b1;
    settle();
    check("midrst_rvalid_in_rst", 32'(cpu_rvalid), 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    check("midrst_rvalid_after", 32'(cpu_rvalid), 32'd0);
    check("midrst_buf_empty", {30'd0, cpu_busy, ram_cs}, 32'd0);

    for (int i = 0; i < 3; i++) next_cycle();
    settle();
    check("vid_scoreboard_drained", 32'(vq.size()), 32'd0);
    check("cpu_scoreboard_drained", 32'(cq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Two-client arbiter and byte-lane adapter that sits directly upstream of the 16K×16 single-port VRAM macro. It multiplexes a 16-bit video fetch port and an 8-bit CPU byte port onto the macro's word address, data, write-mask, write-enable and chip-select pins. It tracks which client owns each one-cycle read return, and buffers one CPU request so the CPU never has to hold its strobe.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied cycles after which a pending CPU access overrides video (range 1–15).
- `clk` in 1: single clock, shared with the VRAM macro.
- `rst` in 1: synchronous, active-high reset.
- `vid_req` in 1: video read request, level, held until acknowledged.
- `vid_addr` in 14: video word address.
- `vid_ack` out 1: video request granted this cycle (combinational).
- `vid_rdata` out 16: video read word.
- `vid_rvalid` out 1: `vid_rdata` valid.
- `cpu_req` in 1: CPU access strobe, one cycle per access.
- `cpu_addr` in 15: CPU byte address; `[14:1]` is the word, `[0]` is the byte lane.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_wdata` in 8: CPU write byte.
- `cpu_busy` out 1: buffer cannot accept `cpu_req` this cycle (combinational).
- `cpu_rdata` out 8: CPU read byte.
- `cpu_rvalid` out 1: `cpu_rdata` valid.
- `ram_ad` out 14, `ram_di` out 16, `ram_maskwe` out 4, `ram_we` out 1, `ram_cs` out 1: macro drive.
- `ram_do` in 16: macro registered read data.
- The macro's `STDBY` and `SLEEP` are tied 0 and `PWROFF_N` is tied 1 at the parent.

## Operation
- CPU buffer is one entry: `buf_valid`, address, `we`, data.
  - Loads on `cpu_req & ~cpu_busy`.
  - `cpu_busy = buf_valid & ~cpu_grant`, so a new request may load in the same cycle the old one is granted.
  - `cpu_req` while `cpu_busy` is dropped. This is a protocol violation and is flagged by a bench assertion.
- Grant, evaluated each cycle:
  - `cpu_grant = buf_valid & (~vid_req | starve_cnt >= STARVE_LIMIT)`.
  - `vid_grant = vid_req & ~cpu_grant`.
  - `vid_ack = vid_grant`.
- Macro drive:
  - Any grant: `ram_cs = 1`.
  - Video grant: `ram_ad = vid_addr`, `ram_we = 0`, `ram_maskwe = 0`.
  - CPU grant: `ram_ad = buf_addr[14:1]`, `ram_di = {buf_data, buf_data}`, `ram_we = buf_we`, `ram_maskwe = buf_addr[0] ? 4'b1100 : 4'b0011`.
  - No grant: all `ram_*` outputs 0.
- Return pipeline: registers `{vid_rd, cpu_rd, lane}` capture the grant type and `buf_addr[0]`.
  - In the following cycle, `vid_rvalid = vid_rd` with `vid_rdata = ram_do`.
  - `cpu_rvalid = cpu_rd` with `cpu_rdata = lane ? ram_do[15:8] : ram_do[7:0]`.
  - CPU writes produce no `rvalid`.
- `starve_cnt` is 4 bits and saturates at `STARVE_LIMIT`.
  - Increments when `buf_valid & ~cpu_grant`.
  - Clears on `cpu_grant` or when `~buf_valid`.
- Reset clears the buffer, `starve_cnt` and the return pipeline. An in-flight read at reset produces no `rvalid`.

## Timing
- Reset values: every output is 0. `cpu_busy` is 0 because `buf_valid` is 0.
- Video read: acked in cycle N; `vid_rvalid` and data in cycle N+1. Back-to-back acks give one word per cycle.
- CPU access: `cpu_req` in cycle A; earliest grant A+1; `cpu_rdata` in A+2.
- CPU write: the macro is written at the end of the grant cycle. A read of the same word granted in the next cycle returns the new byte.
- Continuous `vid_req` with the guard enabled: CPU is granted no later than `STARVE_LIMIT` cycles after buffering. `vid_ack` is 0 that cycle and video must hold its request.
- Simultaneous `cpu_req` load and `cpu_grant` of the prior entry: both occur; no bubble.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN`:
  - Defined: starvation counter and override as above.
  - Undefined: `starve_cnt` is not built, `STARVE_LIMIT` is unused, and video has strict priority (`cpu_grant = buf_valid & ~vid_req`).

## Test plan
- Reset: hold `rst` 2 cycles with `cpu_req=1` and `vid_req=1` → all outputs 0, no `rvalid` the cycle after release.
- Byte write/read: CPU write 0xA5 to 0x0001, then 0x3C to 0x0000, then read 0x0001 → macro sees `ram_maskwe` 4'b1100 then 4'b0011; word 0 holds 0xA53C; `cpu_rdata` is 0xA5 two cycles after its `cpu_req`.
- Video streaming: `vid_req` held for addresses 0x0000–0x0003 with preloaded data → `vid_ack` in 4 consecutive cycles; `vid_rvalid` data in order, each one cycle later.
- Starvation, guard defined, `STARVE_LIMIT=4`: continuous `vid_req` plus one CPU read → CPU granted in the 5th cycle after buffering; `vid_ack` is low exactly that cycle.
- Strict priority, guard undefined: the same stimulus → CPU is never granted while `vid_req` is high; granted the cycle `vid_req` drops.
- Reset mid-read: `rst` asserted in the cycle after a CPU read grant → `cpu_rvalid` stays 0 and the buffer is empty afterwards.
